// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: decodes addressed motor/LED frames from an
// asynchronous SPI master and commits them to registered outputs on ss_n rise.
module spi_cmd_slave #(
    parameter logic [7:0]  SPI_ADDR    = 8'h08,
    parameter int unsigned MIN_SCK_DIV = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic [7:0]  motor_pwm_left_o,
    output logic [7:0]  motor_pwm_rght_o,
    output logic [23:0] led_eye_left_rgb_o,
    output logic [23:0] led_eye_rght_rgb_o,
    output logic [23:0] led_blink_left_rgb_o,
    output logic [23:0] led_blink_rght_rgb_o,
    output logic        cmd_valid,
    output logic [2:0]  cmd_id,
    output logic        frame_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned RGB_W  = 24;
    localparam int unsigned ID_W   = 3;

    localparam logic [BYTE_W-1:0] TYPE_MOTOR = 8'h0A;
    localparam logic [BYTE_W-1:0] TYPE_LED   = 8'h06;
    localparam logic [CNT_W-1:0]  LEN_MOTOR  = CNT_W'(4);
    localparam logic [CNT_W-1:0]  LEN_LED    = CNT_W'(6);

    // Each SCK phase must span at least two clk periods to survive the 2-FF sampling path.
    if (MIN_SCK_DIV < 4) begin : g_div_check
        $error("spi_cmd_slave: MIN_SCK_DIV must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        TYPE = 3'd2,
        SEL  = 3'd3,
        DATA = 3'd4,
        DROP = 3'd5
    } state_t;

    logic sck_meta, sck_sync, sck_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;

    logic sck_rise_c, ss_fall_c, ss_rise_c;
    logic boot_eval_c, ready_c;
    logic [1:0] startup;

    logic [BYTE_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic              byte_done;

    state_t            state, state_next;
    logic [CNT_W-1:0]  frame_len, frame_len_next;
    logic              is_motor, is_motor_next;
    logic [ID_W-1:0]   sel_id, sel_id_next;
    logic [RGB_W-1:0]  staging, staging_next;
    logic              quiet, quiet_next;
    logic              commit_c, err_c;

    // Two-stage synchronizers plus one history stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= spi_ss_n;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise_c = sck_sync & ~sck_prev & ~ss_sync;
    assign ss_fall_c  = ~ss_sync & ss_prev;
    assign ss_rise_c  = ss_sync & ~ss_prev;

    // Counts off the cycles in which the sync chain still holds reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startup <= 2'd0;
        end else if (startup != 2'd3) begin
            startup <= startup + 2'd1;
        end
    end

    assign boot_eval_c = (startup == 2'd2);
    assign ready_c     = (startup == 2'd3);

    // Bit shifter and bit/byte counters; byte_done flags a full byte one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (ss_fall_c) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sck_rise_c) begin
                shreg   <= {shreg[BYTE_W-2:0], mosi_sync};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(7)) begin
                    byte_cnt  <= byte_cnt + CNT_W'(1);
                    byte_done <= 1'b1;
                end
            end
        end
    end

    // Frame decoder state and per-frame context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame_len <= '0;
            is_motor  <= 1'b0;
            sel_id    <= '0;
            staging   <= '0;
            quiet     <= 1'b0;
        end else begin
            state     <= state_next;
            frame_len <= frame_len_next;
            is_motor  <= is_motor_next;
            sel_id    <= sel_id_next;
            staging   <= staging_next;
            quiet     <= quiet_next;
        end
    end

    // Next-state decode; bytes are judged as they complete, frames on ss_n rise.
    always_comb begin
        state_next     = state;
        frame_len_next = frame_len;
        is_motor_next  = is_motor;
        sel_id_next    = sel_id;
        staging_next   = staging;
        quiet_next     = quiet;
        commit_c       = 1'b0;
        err_c          = 1'b0;
        case (state)
            IDLE: begin
                if (boot_eval_c && !ss_sync) begin
                    state_next = DROP;
                    quiet_next = 1'b1;
                end else if (ready_c && ss_fall_c) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (ss_rise_c) begin
                    err_c      = 1'b1;
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = (shreg == SPI_ADDR) ? TYPE : DROP;
                end
            end
            TYPE: begin
                if (ss_rise_c) begin
                    err_c      = 1'b1;
                    state_next = IDLE;
                end else if (byte_done) begin
                    case (shreg)
                        TYPE_MOTOR: begin
                            frame_len_next = LEN_MOTOR;
                            is_motor_next  = 1'b1;
                            state_next     = SEL;
                        end
                        TYPE_LED: begin
                            frame_len_next = LEN_LED;
                            is_motor_next  = 1'b0;
                            state_next     = SEL;
                        end
                        default: state_next = DROP;
                    endcase
                end
            end
            SEL: begin
                if (ss_rise_c) begin
                    err_c      = 1'b1;
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = DATA;
                    if (is_motor) begin
                        case (shreg)
                            8'h01:   sel_id_next = ID_W'(0);
                            8'h02:   sel_id_next = ID_W'(1);
                            default: state_next  = DROP;
                        endcase
                    end else begin
                        case (shreg)
                            8'h02:   sel_id_next = ID_W'(2);
                            8'h01:   sel_id_next = ID_W'(3);
                            8'h04:   sel_id_next = ID_W'(4);
                            8'h08:   sel_id_next = ID_W'(5);
                            default: state_next  = DROP;
                        endcase
                    end
                end
            end
            DATA: begin
                if (ss_rise_c) begin
                    if (byte_cnt == frame_len && bit_cnt == '0) begin
                        commit_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                    state_next = IDLE;
                end else if (byte_done) begin
                    // byte_cnt already counts the byte just completed
                    if (byte_cnt > frame_len) begin
                        state_next = DROP;
                    end else begin
                        case (byte_cnt)
                            CNT_W'(4): staging_next[23:16] = shreg;
                            CNT_W'(5): staging_next[15:8]  = shreg;
                            default:   staging_next[7:0]   = shreg;
                        endcase
                    end
                end
            end
            DROP: begin
                if (ss_rise_c) begin
                    err_c      = !quiet;
                    quiet_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Committed command registers and the one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor_pwm_left_o     <= '0;
            motor_pwm_rght_o     <= '0;
            led_eye_left_rgb_o   <= '0;
            led_eye_rght_rgb_o   <= '0;
            led_blink_left_rgb_o <= '0;
            led_blink_rght_rgb_o <= '0;
            cmd_valid            <= 1'b0;
            cmd_id               <= '0;
            frame_err            <= 1'b0;
        end else begin
            cmd_valid <= commit_c;
            frame_err <= err_c;
            if (commit_c) begin
                cmd_id <= sel_id;
                case (sel_id)
                    ID_W'(0): motor_pwm_left_o     <= staging[23:16];
                    ID_W'(1): motor_pwm_rght_o     <= staging[23:16];
                    ID_W'(2): led_eye_left_rgb_o   <= staging;
                    ID_W'(3): led_eye_rght_rgb_o   <= staging;
                    ID_W'(4): led_blink_left_rgb_o <= staging;
                    ID_W'(5): led_blink_rght_rgb_o <= staging;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: directed frame table, reset-in-frame sequence and
// random frames checked against a frame-level reference model.
module tb_spi_cmd_slave;

    localparam int CLK_P = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic [7:0]  motor_l, motor_r;
    logic [23:0] eye_l, eye_r, blink_l, blink_r;
    logic        cmd_valid;
    logic [2:0]  cmd_id;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    logic [23:0] exp_regs [6];
    logic [2:0]  exp_id;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          extra;
        int          div;
        bit          ok;
        logic [2:0]  id;
        logic [23:0] val;
    } vec_t;

    vec_t vecs [13];

    spi_cmd_slave #(.SPI_ADDR(8'h08), .MIN_SCK_DIV(6)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .spi_sck              (spi_sck),
        .spi_ss_n             (spi_ss_n),
        .spi_mosi             (spi_mosi),
        .motor_pwm_left_o     (motor_l),
        .motor_pwm_rght_o     (motor_r),
        .led_eye_left_rgb_o   (eye_l),
        .led_eye_rght_rgb_o   (eye_r),
        .led_blink_left_rgb_o (blink_l),
        .led_blink_rght_rgb_o (blink_r),
        .cmd_valid            (cmd_valid),
        .cmd_id               (cmd_id),
        .frame_err            (frame_err)
    );

    always #(CLK_P/2) clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) valid_cnt++;
            if (frame_err) err_cnt++;
            if (cmd_valid && frame_err) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] outs_now();
        return 128'({motor_l, motor_r, eye_l, eye_r, blink_l, blink_r});
    endfunction

    function automatic logic [127:0] outs_exp();
        return 128'({exp_regs[0][23:16], exp_regs[1][23:16], exp_regs[2],
                     exp_regs[3], exp_regs[4], exp_regs[5]});
    endfunction

    // Frame-level reference: whole frame accepted or not, from the command rules.
    function automatic void model(input logic [63:0] bytes, input int n, input int extra,
                                  output bit ok, output logic [2:0] id, output logic [23:0] val);
        logic [7:0] b [8];
        int flen;
        for (int i = 0; i < 8; i++) b[i] = bytes[63-8*i -: 8];
        ok = 1'b0;
        id = 3'd0;
        val = 24'd0;
        if (n < 3 || b[0] != 8'h08) return;
        if (b[1] == 8'h0A) flen = 4;
        else if (b[1] == 8'h06) flen = 6;
        else return;
        if (flen == 4) begin
            if (b[2] == 8'h01) id = 3'd0;
            else if (b[2] == 8'h02) id = 3'd1;
            else return;
        end else begin
            if (b[2] == 8'h02) id = 3'd2;
            else if (b[2] == 8'h01) id = 3'd3;
            else if (b[2] == 8'h04) id = 3'd4;
            else if (b[2] == 8'h08) id = 3'd5;
            else return;
        end
        if (n != flen || extra != 0) return;
        ok = 1'b1;
        val = (flen == 4) ? {b[3], 16'h0000} : {b[3], b[4], b[5]};
    endfunction

    task automatic send_bit(input logic b, input int div);
        spi_mosi = b;
        #(div*CLK_P/2);
        spi_sck = 1'b1;
        #(div*CLK_P/2);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int div);
        for (int k = 7; k >= 0; k--) send_bit(v[k], div);
    endtask

    // One complete frame followed by latency, pulse and register checks.
    task automatic run_frame(input logic [63:0] bytes, input int n, input int extra, input int div,
                             input bit ok, input logic [2:0] id, input logic [23:0] val);
        int v0, e0;
        logic [7:0] nb;
        #(CLK_P);
        v0 = valid_cnt;
        e0 = err_cnt;
        spi_ss_n = 1'b0;
        #(div*CLK_P/2);
        for (int i = 0; i < n; i++) send_byte(bytes[63-8*i -: 8], div);
        if (extra > 0) begin
            nb = bytes[63-8*n -: 8];
            for (int k = 7; k > 7 - extra; k--) send_bit(nb[k], div);
        end
        #(div*CLK_P/2);
        spi_ss_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_pulse", 128'({cmd_valid, frame_err}), 128'(0));
        @(posedge clk);
        #1;
        check("pulse", 128'({cmd_valid, frame_err}), 128'({ok, !ok}));
        if (ok) begin
            exp_regs[id] = val;
            exp_id = id;
        end
        check("cmd_id", 128'(cmd_id), 128'(exp_id));
        check("outputs", outs_now(), outs_exp());
        @(posedge clk);
        #1;
        check("one_cycle", 128'({cmd_valid, frame_err}), 128'(0));
        check("pulse_count", 128'({32'(valid_cnt - v0), 32'(err_cnt - e0)}),
              128'({32'(ok ? 1 : 0), 32'(ok ? 0 : 1)}));
    endtask

    initial begin
        logic [63:0] bytes;
        logic [7:0]  tbyte;
        int n, extra, div, flen, v0, e0;
        bit ok;
        logic [2:0] id;
        logic [23:0] val;

        vecs[0]  = '{64'h08_0A_01_9C_00_00_00_00, 4, 0, 24, 1'b1, 3'd0, 24'h9C0000};
        vecs[1]  = '{64'h08_06_01_FF_80_00_00_00, 6, 0, 6,  1'b1, 3'd3, 24'hFF8000};
        vecs[2]  = '{64'h09_0A_02_10_00_00_00_00, 4, 0, 6,  1'b0, 3'd0, 24'h0};
        vecs[3]  = '{64'h08_06_03_11_22_33_00_00, 6, 0, 6,  1'b0, 3'd0, 24'h0};
        vecs[4]  = '{64'h08_0A_02_10_00_00_00_00, 3, 4, 6,  1'b0, 3'd0, 24'h0};
        vecs[5]  = '{64'h08_0A_02_10_20_00_00_00, 5, 0, 6,  1'b0, 3'd0, 24'h0};
        vecs[6]  = '{64'h08_0A_02_7F_00_00_00_00, 4, 0, 6,  1'b1, 3'd1, 24'h7F0000};
        vecs[7]  = '{64'h00_00_00_00_00_00_00_00, 0, 0, 6,  1'b0, 3'd0, 24'h0};
        vecs[8]  = '{64'h08_06_08_01_02_03_00_00, 6, 0, 6,  1'b1, 3'd5, 24'h010203};
        vecs[9]  = '{64'h08_06_02_A5_5A_C3_00_00, 6, 0, 6,  1'b1, 3'd2, 24'hA55AC3};
        vecs[10] = '{64'h08_06_04_DE_AD_BE_00_00, 6, 0, 7,  1'b1, 3'd4, 24'hDEADBE};
        vecs[11] = '{64'h08_0A_01_80_00_00_00_00, 4, 0, 6,  1'b1, 3'd0, 24'h800000};
        vecs[12] = '{64'h08_06_01_12_34_00_00_00, 5, 0, 6,  1'b0, 3'd0, 24'h0};

        for (int i = 0; i < 6; i++) exp_regs[i] = 24'h0;
        exp_id = 3'd0;

        rst = 1'b1;
        spi_sck = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        #22;
        check("reset_outputs", outs_now(), 128'(0));
        check("reset_status", 128'({cmd_id, cmd_valid, frame_err}), 128'(0));
        rst = 1'b0;
        #(5*CLK_P);

        // Directed frames, back to back.
        for (int i = 0; i < 13; i++) begin
            run_frame(vecs[i].bytes, vecs[i].n, vecs[i].extra, vecs[i].div,
                      vecs[i].ok, vecs[i].id, vecs[i].val);
        end

        // Random frames against the reference model.
        for (int f = 0; f < 30; f++) begin
            bytes = {$urandom, $urandom};
            bytes[63:56] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h08;
            case ($urandom_range(0, 4))
                0, 1:    tbyte = 8'h0A;
                2, 3:    tbyte = 8'h06;
                default: tbyte = 8'($urandom);
            endcase
            bytes[55:48] = tbyte;
            case ($urandom_range(0, 4))
                0:       bytes[47:40] = 8'h01;
                1:       bytes[47:40] = 8'h02;
                2:       bytes[47:40] = 8'h04;
                3:       bytes[47:40] = 8'h08;
                default: bytes[47:40] = 8'($urandom);
            endcase
            flen = (tbyte == 8'h0A) ? 4 : 6;
            n = flen;
            if ($urandom_range(0, 5) == 0) n = ($urandom_range(0, 1) == 1) ? flen + 1 : flen - 1;
            extra = (n < 7 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
            div = int'($urandom_range(6, 16));
            model(bytes, n, extra, ok, id, val);
            run_frame(bytes, n, extra, div, ok, id, val);
        end

        // Reset in the middle of a frame with ss_n held low.
        #(CLK_P);
        bytes = 64'h08_06_04_11_22_33_00_00;
        spi_ss_n = 1'b0;
        #30;
        for (int i = 0; i < 4; i++) send_byte(bytes[63-8*i -: 8], 6);
        #30;
        rst = 1'b1;
        #(3*CLK_P);
        check("rst_mid_outputs", outs_now(), 128'(0));
        check("rst_mid_status", 128'({cmd_id, cmd_valid, frame_err}), 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) exp_regs[i] = 24'h0;
        exp_id = 3'd0;
        v0 = valid_cnt;
        e0 = err_cnt;
        #(3*CLK_P);
        for (int i = 4; i < 6; i++) send_byte(bytes[63-8*i -: 8], 6);
        #30;
        spi_ss_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_quiet", 128'({32'(valid_cnt - v0), 32'(err_cnt - e0)}), 128'(0));
        check("rst_hold", outs_now(), outs_exp());
        run_frame(bytes, 6, 0, 6, 1'b1, 3'd4, 24'h112233);

        check("overlap", 128'(both_cnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
